// File: rtl/mem_arb2_pkg.sv
// Shared definitions for the two-port memory arbiter: state encodings and default sizes.
package mem_arb2_pkg;

   localparam int unsigned AW_DEF        = 10;
   localparam int unsigned DW_DEF        = 8;
   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned STATS_W       = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwnA = 2'd1,
      StOwnB = 2'd2
   } state_e;

endpackage

// File: rtl/mem_arb2_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the port that was not last.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester arbiter in front of a single-port synchronous memory with bounded bursts.
// Optional grant counters are built when MEM_ARB2_STATS_EN is defined.
module mem_arb2
   import mem_arb2_pkg::*;
#(
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned DW        = DW_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_a,
   input  logic               we_a,
   input  logic [AW-1:0]      addr_a,
   input  logic [DW-1:0]      wdata_a,
   input  logic               req_b,
   input  logic               we_b,
   input  logic [AW-1:0]      addr_b,
   input  logic [DW-1:0]      wdata_b,
   output logic               gnt_a,
   output logic               gnt_b,
   output logic               rvalid_a,
   output logic               rvalid_b,
   output logic [DW-1:0]      rdata,
   output logic               mem_cs,
   output logic               mem_wr,
   output logic               mem_rd,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
`ifdef MEM_ARB2_STATS_EN
   input  logic               stats_clr,
   output logic [STATS_W-1:0] gnt_cnt_a,
   output logic [STATS_W-1:0] gnt_cnt_b,
`endif
   input  logic [DW-1:0]      mem_rdata
);

   localparam int unsigned BW = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

   state_e        state_q;
   logic [BW-1:0] beat_cnt_q;
   logic          last_gnt_q;
   logic          rvalid_a_q, rvalid_b_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;

   logic [1:0] rr_gnt;
   logic       pick_a, pick_b;
   logic       beat_last, any_gnt, sel_we, same_owner;

   rr_pick2 u_rr_pick2 (
      .req      ({req_b, req_a}),
      .last_gnt (last_gnt_q),
      .gnt      (rr_gnt)
   );

   assign beat_last = (beat_cnt_q == BEAT_LAST);

   always_comb begin
      pick_a = 1'b0;
      pick_b = 1'b0;
      unique case (state_q)
         StOwnA: begin
            if (req_a && !(beat_last && req_b)) pick_a = 1'b1;
            else if (req_b)                     pick_b = 1'b1;
         end
         StOwnB: begin
            if (req_b && !(beat_last && req_a)) pick_b = 1'b1;
            else if (req_a)                     pick_a = 1'b1;
         end
         default: {pick_b, pick_a} = rr_gnt;
      endcase
   end

   // Gating with rst_n keeps every strobe low for the whole reset pulse.
   assign gnt_a   = pick_a & rst_n;
   assign gnt_b   = pick_b & rst_n;
   assign any_gnt = gnt_a | gnt_b;
   assign sel_we  = gnt_b ? we_b : we_a;

   assign mem_cs    = any_gnt;
   assign mem_wr    = any_gnt & sel_we;
   assign mem_rd    = any_gnt & ~sel_we;
   assign mem_addr  = gnt_a ? addr_a  : (gnt_b ? addr_b  : addr_q);
   assign mem_wdata = gnt_a ? wdata_a : (gnt_b ? wdata_b : wdata_q);

   assign rvalid_a = rvalid_a_q;
   assign rvalid_b = rvalid_b_q;
   assign rdata    = mem_rdata;

   assign same_owner = (gnt_a && state_q == StOwnA) || (gnt_b && state_q == StOwnB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         beat_cnt_q <= '0;
         last_gnt_q <= 1'b1;
         rvalid_a_q <= 1'b0;
         rvalid_b_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         rvalid_a_q <= gnt_a & ~we_a;
         rvalid_b_q <= gnt_b & ~we_b;
         if (any_gnt) begin
            state_q    <= gnt_a ? StOwnA : StOwnB;
            last_gnt_q <= gnt_b;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            // Saturate so a lone owner cannot wrap past the burst limit.
            if (!same_owner)     beat_cnt_q <= '0;
            else if (!beat_last) beat_cnt_q <= beat_cnt_q + 1'b1;
         end else begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
         end
      end
   end

`ifdef MEM_ARB2_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_cnt_a <= '0;
         gnt_cnt_b <= '0;
      end else if (stats_clr) begin
         gnt_cnt_a <= '0;
         gnt_cnt_b <= '0;
      end else begin
         if (gnt_a && gnt_cnt_a != '1) gnt_cnt_a <= gnt_cnt_a + 1'b1;
         if (gnt_b && gnt_cnt_b != '1) gnt_cnt_b <= gnt_cnt_b + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with a behavioural 1K x 8 registered-read memory.
module tb_mem_arb2;

   logic        clk;
   logic        rst_n;
   logic        req_a, we_a, req_b, we_b;
   logic [9:0]  addr_a, addr_b;
   logic [7:0]  wdata_a, wdata_b;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0]  rdata;
   logic        mem_cs, mem_wr, mem_rd;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
`ifdef MEM_ARB2_STATS_EN
   logic        stats_clr;
   logic [15:0] gnt_cnt_a, gnt_cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [1024];

   mem_arb2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_a     (req_a),
      .we_a      (we_a),
      .addr_a    (addr_a),
      .wdata_a   (wdata_a),
      .req_b     (req_b),
      .we_b      (we_b),
      .addr_b    (addr_b),
      .wdata_b   (wdata_b),
      .gnt_a     (gnt_a),
      .gnt_b     (gnt_b),
      .rvalid_a  (rvalid_a),
      .rvalid_b  (rvalid_b),
      .rdata     (rdata),
      .mem_cs    (mem_cs),
      .mem_wr    (mem_wr),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
`ifdef MEM_ARB2_STATS_EN
      .stats_clr (stats_clr),
      .gnt_cnt_a (gnt_cnt_a),
      .gnt_cnt_b (gnt_cnt_b),
`endif
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_cs && mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_cs && mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL rst_gnt_a: got %b exp 0", gnt_a); end
      checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL rst_gnt_b: got %b exp 0", gnt_b); end
      checks++; if ({mem_cs, mem_wr, mem_rd} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b exp 000", {mem_cs, mem_wr, mem_rd}); end
      checks++; if ({rvalid_a, rvalid_b} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b exp 00", {rvalid_a, rvalid_b}); end
      checks++; if (mem_addr !== 10'h000) begin errors++; $display("FAIL rst_mem_addr: got %h exp 000", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL rst_mem_wdata: got %h exp 00", mem_wdata); end
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_tie;
      req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 10'h000; addr_b = 10'h000;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL tie_first: got a%b b%b exp a1 b0", gnt_a, gnt_b); end
      tick();
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b, mem_cs} !== 3'b000) begin errors++; $display("FAIL tie_idle: got %b exp 000", {gnt_a, gnt_b, mem_cs}); end
      tick();
      req_a = 1'b1; req_b = 1'b1;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b} !== 2'b01) begin errors++; $display("FAIL tie_second: got a%b b%b exp a0 b1", gnt_a, gnt_b); end
      tick();
      req_a = 1'b0; req_b = 1'b0;
      tick();
   endtask

   task automatic test_write_read;
      req_a = 1'b1; we_a = 1'b1; addr_a = 10'h005; wdata_a = 8'hA5;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got a%b b%b exp a1 b0", gnt_a, gnt_b); end
      checks++; if ({mem_cs, mem_wr, mem_rd} !== 3'b110) begin errors++; $display("FAIL wr_strobes: got %b exp 110", {mem_cs, mem_wr, mem_rd}); end
      checks++; if (mem_addr !== 10'h005 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_bus: got %h/%h exp 005/a5", mem_addr, mem_wdata); end
      tick();
      we_a = 1'b0;
      checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b exp 0", rvalid_a); end
      @(negedge clk);
      checks++; if (gnt_a !== 1'b1 || {mem_cs, mem_wr, mem_rd} !== 3'b101) begin errors++; $display("FAIL rd_gnt: got gnt %b strobes %b exp 1 101", gnt_a, {mem_cs, mem_wr, mem_rd}); end
      tick();
      req_a = 1'b0;
      checks++; if (rvalid_a !== 1'b1 || rdata !== 8'hA5) begin errors++; $display("FAIL rd_data: got v%b %h exp v1 a5", rvalid_a, rdata); end
      checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL rd_rvalid_b: got %b exp 0", rvalid_b); end
      @(negedge clk);
      checks++; if (mem_cs !== 1'b0 || mem_addr !== 10'h005 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL hold_bus: got cs%b %h/%h exp cs0 005/a5", mem_cs, mem_addr, mem_wdata); end
      tick();
      checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL rd_rvalid_drop: got %b exp 0", rvalid_a); end
   endtask

   task automatic test_mid_burst;
      req_a = 1'b1; we_a = 1'b0; addr_a = 10'h005;
      repeat (2) begin
         @(negedge clk);
         checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL burst_a: got %b exp 1", gnt_a); end
         tick();
      end
      req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 10'h000;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b} !== 2'b01 || mem_addr !== 10'h000) begin errors++; $display("FAIL drop_switch: got a%b b%b %h exp a0 b1 000", gnt_a, gnt_b, mem_addr); end
      tick();
      req_b = 1'b0;
      tick();
   endtask

   task automatic test_fairness;
      logic exp_b;
      req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0; addr_a = 10'h005; addr_b = 10'h000;
      for (int i = 0; i < 12; i++) begin
         exp_b = ((i / 4) % 2) == 1;
         @(negedge clk);
         checks++;
         if (gnt_a !== ~exp_b || gnt_b !== exp_b) begin
            errors++;
            $display("FAIL fair_%0d: got a%b b%b exp a%b b%b", i, gnt_a, gnt_b, ~exp_b, exp_b);
         end
         tick();
      end
      req_a = 1'b0; req_b = 1'b0;
      tick();
   endtask

   task automatic test_same_addr;
      req_b = 1'b1; we_b = 1'b1; addr_b = 10'h3FF; wdata_b = 8'h3C;
      @(negedge clk);
      checks++; if (gnt_b !== 1'b1 || mem_wr !== 1'b1) begin errors++; $display("FAIL pre_wr: got gnt%b wr%b exp 1 1", gnt_b, mem_wr); end
      tick();
      we_b = 1'b0;
      @(negedge clk);
      checks++; if (gnt_b !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 10'h3FF) begin errors++; $display("FAIL b_rd: got gnt%b rd%b %h exp 1 1 3ff", gnt_b, mem_rd, mem_addr); end
      tick();
      req_b = 1'b0; req_a = 1'b1; we_a = 1'b1; addr_a = 10'h3FF; wdata_a = 8'h77;
      checks++; if (rvalid_b !== 1'b1 || rdata !== 8'h3C) begin errors++; $display("FAIL b_old_data: got v%b %h exp v1 3c", rvalid_b, rdata); end
      @(negedge clk);
      checks++; if (gnt_a !== 1'b1 || mem_wdata !== 8'h77 || mem_wr !== 1'b1) begin errors++; $display("FAIL a_wr: got gnt%b %h wr%b exp 1 77 1", gnt_a, mem_wdata, mem_wr); end
      tick();
      we_a = 1'b0;
      checks++; if ({rvalid_a, rvalid_b} !== 2'b00) begin errors++; $display("FAIL a_wr_rvalid: got %b exp 00", {rvalid_a, rvalid_b}); end
      @(negedge clk);
      tick();
      req_a = 1'b0;
      checks++; if (rvalid_a !== 1'b1 || rdata !== 8'h77) begin errors++; $display("FAIL a_new_data: got v%b %h exp v1 77", rvalid_a, rdata); end
      tick();
   endtask

   task automatic test_reset_inflight;
      req_a = 1'b1; we_a = 1'b0; addr_a = 10'h005;
      @(negedge clk);
      checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL inflight_gnt: got %b exp 1", gnt_a); end
      tick();
      rst_n = 1'b0;
      #1;
      checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL inflight_rvalid: got %b exp 0", rvalid_a); end
      checks++; if ({gnt_a, mem_cs, mem_rd} !== 3'b000 || mem_addr !== 10'h000) begin errors++; $display("FAIL inflight_bus: got %b %h exp 000 000", {gnt_a, mem_cs, mem_rd}, mem_addr); end
      tick();
      checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL inflight_rvalid2: got %b exp 0", rvalid_a); end
      req_a = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      tick();
      req_a = 1'b1; req_b = 1'b1; we_b = 1'b0; addr_b = 10'h3FF;
      @(negedge clk);
      checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL resume_tie: got a%b b%b exp a1 b0", gnt_a, gnt_b); end
      tick();
      req_a = 1'b0; req_b = 1'b0;
      checks++; if (rvalid_a !== 1'b1 || rvalid_b !== 1'b0 || rdata !== 8'hA5) begin errors++; $display("FAIL resume_rd: got va%b vb%b %h exp 1 0 a5", rvalid_a, rvalid_b, rdata); end
      tick();
   endtask

`ifdef MEM_ARB2_STATS_EN
   task automatic test_stats;
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      checks++; if (gnt_cnt_a !== 16'd0 || gnt_cnt_b !== 16'd0) begin errors++; $display("FAIL stats_zero: got %0d/%0d exp 0/0", gnt_cnt_a, gnt_cnt_b); end
      req_a = 1'b1; we_a = 1'b0; addr_a = 10'h000;
      repeat (5) tick();
      req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 10'h000;
      repeat (3) tick();
      req_b = 1'b0;
      tick();
      checks++; if (gnt_cnt_a !== 16'd5 || gnt_cnt_b !== 16'd3) begin errors++; $display("FAIL stats_count: got %0d/%0d exp 5/3", gnt_cnt_a, gnt_cnt_b); end
      req_a = 1'b1; stats_clr = 1'b1;
      @(negedge clk);
      checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL stats_clr_gnt: got %b exp 1", gnt_a); end
      tick();
      stats_clr = 1'b0; req_a = 1'b0;
      checks++; if (gnt_cnt_a !== 16'd0 || gnt_cnt_b !== 16'd0) begin errors++; $display("FAIL stats_clr: got %0d/%0d exp 0/0", gnt_cnt_a, gnt_cnt_b); end
      tick();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
      req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
`ifdef MEM_ARB2_STATS_EN
      stats_clr = 1'b0;
`endif
      test_reset();
      test_tie();
      test_write_read();
      test_mid_burst();
      test_fairness();
      test_same_addr();
      test_reset_inflight();
`ifdef MEM_ARB2_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arb2.md
Name: mem_arb2

Overview:
- Two-requester arbiter/sequencer in front of the 1K x 8 single-port synchronous memory (cs/wr/rd strobes, 10-bit addr, 8-bit data, 1-cycle registered read).
- Grants one access per cycle, with round-robin fairness and a bounded burst per owner.
- Drives the memory strobes and returns read data with a per-port valid.
- Sits between two bus masters (e.g. CPU-side and DMA-side) and the memory.

Parameters:
- AW, 10, address width (1024 words).
- DW, 8, data width.
- MAX_BURST, 4, max consecutive grants to one owner while the other port waits; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_a / req_b  in  1  access request; command fields must be stable while req is high
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  AW  word address
- wdata_a / wdata_b  in  DW  write data
- gnt_a / gnt_b  out  1  combinational; access performed at the clk edge where req_x && gnt_x
- rvalid_a / rvalid_b  out  1  registered; high the cycle after a granted read
- rdata  out  DW  shared read data = mem_rdata; qualified by rvalid_x
- mem_cs, mem_wr, mem_rd  out  1  memory strobes
- mem_addr  out  AW
- mem_wdata  out  DW
- mem_rdata  in  DW  memory data_out

Behaviour:
- State machine (registered): IDLE, OWN_A, OWN_B.
- Per-owner registers: beat_cnt, width $clog2(MAX_BURST)+1; last_gnt, 0 = A, 1 = B.
- Grant decision (combinational, each cycle):
  - In OWN_x: if req_x && !(beat_cnt == MAX_BURST-1 && req_other), grant x. Else if req_other, grant other. Else no grant.
  - In IDLE: single requester wins. On a tie, grant the port != last_gnt.
- At most one gnt high per cycle. gnt is never high without the matching req.
- Memory drive while a grant is active:
  - mem_cs = 1, mem_wr = we, mem_rd = !we.
  - mem_addr and mem_wdata are muxed from the granted port.
  - mem_wr and mem_rd are never both 1.
- No grant: mem_cs = mem_wr = mem_rd = 0; mem_addr and mem_wdata hold the last granted value (registered copy).
- Next state:
  - Granted port becomes owner. beat_cnt increments if the owner is unchanged, else loads 0.
  - last_gnt updates on every grant.
  - No grant: go to IDLE, beat_cnt = 0.
- Read latency:
  - Read granted at edge N: memory registers data at edge N.
  - rvalid_x = 1 during cycle N+1; rdata valid that cycle.
  - Back-to-back reads from alternating ports give alternating rvalids.
- Write: takes effect at the grant edge. No rvalid.
- Fairness: with both ports requesting continuously, pattern is MAX_BURST grants to one port, then MAX_BURST to the other. MAX_BURST = 1 gives strict alternation.
- Owner drops req mid-burst: the other port is granted the same cycle, or IDLE if it is not requesting.
- Reset (async assert, sync deassert assumed upstream):
  - State IDLE, beat_cnt 0, last_gnt = 1 so A wins the first tie.
  - rvalid_a = rvalid_b = 0; registered mem_addr and mem_wdata = 0.
  - All strobes 0 while rst_n = 0.
  - A read in flight when reset asserts is dropped: no rvalid.

Optional Feature:
- Macro MEM_ARB2_STATS_EN.
- Defined:
  - Adds output ports gnt_cnt_a and gnt_cnt_b (16 bits each) and input stats_clr.
  - Each counter increments on each grant to its port and saturates at 16'hFFFF.
  - stats_clr synchronously zeroes both counters; clear wins over increment in the same cycle.
  - Reset zeroes both counters.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package/include (mem_arb_defs): state encodings ST_IDLE = 2'd0, ST_OWN_A = 2'd1, ST_OWN_B = 2'd2; default AW, DW, MAX_BURST; stats counter width 16.
- Sub-module: rr_pick2 (combinational two-way round-robin chooser: req pair, last_gnt -> one-hot grant), reused in the IDLE tie case.
- The memory itself is instantiated in the bench or top level, not inside mem_arb2.

Test Plan:
- Reset release, A writes addr 10'h005 = 8'hA5, then A reads 10'h005 -> gnt_a in both cycles; rvalid_a one cycle after the read grant; rdata = 8'hA5; rvalid_b stays 0.
- req_a and req_b both held high for 12 cycles with MAX_BURST = 4 -> grants A,A,A,A,B,B,B,B,A,A,A,A; never both gnt high.
- First-cycle tie after reset -> A granted. A then drops req: next tie goes to B (last_gnt = A).
- B reads 10'h3FF (preloaded 8'h3C) while A writes 10'h3FF = 8'h77 in the next grant -> B sees 8'h3C; a subsequent A read returns 8'h77.
- rst_n pulsed low the cycle after a read grant -> rvalid stays 0, strobes 0, state IDLE; traffic resumes correctly after release.
- MEM_ARB2_STATS_EN defined: 5 grants to A and 3 to B -> gnt_cnt_a = 5, gnt_cnt_b = 3. Pulse stats_clr during a grant -> both counters read 0.
